// File: rtl/sha1_stream_if.sv
// Byte stream carrying message bytes into the SHA-1 front end.
// The source drives data/valid/last; the sink answers with ready.
interface sha1_stream_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, valid, last, input ready);
    modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/sha1_stream_ctrl.sv
// Packs a byte stream big-endian into 512-bit SHA-1 blocks, appends padding and the
// 64-bit bit length, sequences the core one block at a time and latches the digest.
module sha1_stream_ctrl #(
    parameter int LEN_W = 61
) (
    input  logic                clk,
    input  logic                reset,
    sha1_stream_if.slave        msg,
    output logic                core_init,
    output logic                core_next,
    output logic [511:0]        core_block,
    input  logic                core_ready,
    input  logic [159:0]        core_digest,
    output logic [159:0]        digest,
    output logic                digest_valid,
    output logic                busy
);

    typedef enum logic [2:0] {
        FILL,
        PAD,
        LEN,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [5:0]         idx;
    logic [LEN_W-1:0]   byte_cnt;
    logic               first_block;
    logic               marker_done;
    logic               final_blk;
    logic               pend_last;
    logic [511:0]       block;
    logic               accept;
    logic               pad_write;
    logic [63:0]        len_bits;

    assign core_block = block;
    assign busy       = (state != FILL);
    assign len_bits   = 64'({byte_cnt, 3'b000});

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        msg.ready = 1'b0;
        core_init = 1'b0;
        core_next = 1'b0;
        accept    = 1'b0;
        pad_write = 1'b0;
        case (state)
            FILL: begin
                msg.ready = ~reset;
                accept    = msg.valid & ~reset;
                if (accept) begin
                    if (idx == 6'd63) begin
                        state_nxt = ISSUE;
                    end else if (msg.last) begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (idx == 6'd56 && marker_done) begin
                    state_nxt = LEN;
                end else begin
                    pad_write = 1'b1;
                    if (idx == 6'd63) begin
                        state_nxt = ISSUE;
                    end
                end
            end
            LEN: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                // Pulse is combinational so it can never be seen while the core is busy.
                if (core_ready && !reset) begin
                    core_init = first_block;
                    core_next = ~first_block;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!core_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_ready) begin
                    if (final_blk) begin
                        state_nxt = FILL;
                    end else if (pend_last || marker_done) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // NOTE: the block register is cleared on reset because the core may read it at any time.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= 6'd0;
            byte_cnt     <= '0;
            first_block  <= 1'b1;
            marker_done  <= 1'b0;
            final_blk    <= 1'b0;
            pend_last    <= 1'b0;
            block        <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        block[{~idx, 3'b111} -: 8] <= msg.data;
                        idx          <= idx + 6'd1;
                        byte_cnt     <= byte_cnt + LEN_W'(1);
                        digest_valid <= 1'b0;
                        if (idx == 6'd63) begin
                            final_blk <= 1'b0;
                            pend_last <= msg.last;
                        end
                    end
                end
                PAD: begin
                    if (pad_write) begin
                        block[{~idx, 3'b111} -: 8] <= marker_done ? 8'h00 : 8'h80;
                        marker_done <= 1'b1;
                        idx         <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            final_blk <= 1'b0;
                        end
                    end
                end
                LEN: begin
                    block[63:0] <= len_bits;
                    final_blk   <= 1'b1;
                end
                ISSUE: begin
                    if (core_ready) begin
                        first_block <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (core_ready) begin
                        block <= '0;
                        idx   <= 6'd0;
                        if (final_blk) begin
                            digest       <= core_digest;
                            digest_valid <= 1'b1;
                            byte_cnt     <= '0;
                            first_block  <= 1'b1;
                            marker_done  <= 1'b0;
                            pend_last    <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_stream_ctrl.sv
// Directed bench for sha1_stream_ctrl with a behavioural SHA-1 core that hashes each issued block.
module tb_sha1_stream_ctrl;

    localparam logic [159:0] H0      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] S2_DIG  = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
    localparam logic [447:0] S2      = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    localparam logic [511:0] S2_BLK0 = {S2, 8'h80, 56'h0};
    localparam logic [511:0] S2_BLK1 = {448'h0, 64'h1C0};
    localparam logic [511:0] Z_BLK1  = {8'h80, 440'h0, 64'h200};

    logic         clk;
    logic         reset;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic         core_ready;
    logic [159:0] core_digest;
    logic [159:0] digest;
    logic         digest_valid;
    logic         busy;

    sha1_stream_if msg ();

    sha1_stream_ctrl #(.LEN_W(61)) dut (
        .clk          (clk),
        .reset        (reset),
        .msg          (msg),
        .core_init    (core_init),
        .core_next    (core_next),
        .core_block   (core_block),
        .core_ready   (core_ready),
        .core_digest  (core_digest),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp, x;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {x[30:0], x[31]};
        end
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Behavioural core: goes busy the cycle after a pulse, idle again four cycles later.
    logic         model_ready = 1'b1;
    logic         hold = 1'b0;
    int           busy_cnt = 0;
    int           init_cnt = 0;
    int           next_cnt = 0;
    int           pulse_cnt = 0;
    int           viol_cnt = 0;
    logic [511:0] blk_log [16];

    assign core_ready = model_ready & ~hold;

    initial core_digest = '0;

    always @(posedge clk) begin : core_model
        logic [159:0] base;
        if (core_init && core_next) viol_cnt <= viol_cnt + 1;
        if ((core_init || core_next) && (!core_ready || reset)) viol_cnt <= viol_cnt + 1;
        if (core_init || core_next) begin
            base = core_init ? H0 : core_digest;
            core_digest <= sha1_compress(base, core_block);
            blk_log[pulse_cnt % 16] <= core_block;
            pulse_cnt   <= pulse_cnt + 1;
            init_cnt    <= init_cnt + (core_init ? 1 : 0);
            next_cnt    <= next_cnt + (core_next ? 1 : 0);
            model_ready <= 1'b0;
            busy_cnt    <= 4;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) model_ready <= 1'b1;
        end
    end

    logic [7:0] q[$];
    int base_p, base_i, base_n;

    task automatic snap();
        base_p = pulse_cnt;
        base_i = init_cnt;
        base_n = next_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int t = 0;
        msg.data  = b;
        msg.valid = 1'b1;
        msg.last  = last;
        while (!msg.ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("send_timeout", 512'(msg.ready), 512'(1));
        @(negedge clk);
        msg.valid = 1'b0;
        msg.last  = 1'b0;
    endtask

    task automatic send_msg();
        for (int i = 0; i < q.size(); i++) send_byte(q[i], i == q.size() - 1);
    endtask

    task automatic wait_digest(input string tag);
        int t = 0;
        while (!digest_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 512'(digest_valid), 512'(1));
    endtask

    task automatic load_abc();
        q = '{8'h61, 8'h62, 8'h63};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses_seen, blk_changed, ready_seen;
        reset     = 1'b1;
        msg.data  = 8'h00;
        msg.valid = 1'b0;
        msg.last  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready_low", 512'(msg.ready), 512'(0));
        check("rst_no_pulse", 512'({core_init, core_next}), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_block", core_block, 512'(0));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_dvalid_busy", 512'({digest_valid, busy}), 512'(0));
        check("rst_in_ready_high", 512'(msg.ready), 512'(1));

        // 1: "abc"
        snap();
        load_abc();
        send_msg();
        wait_digest("abc_done");
        check("abc_inits", 512'(init_cnt - base_i), 512'(1));
        check("abc_nexts", 512'(next_cnt - base_n), 512'(0));
        check("abc_block", blk_log[base_p % 16], ABC_BLK);
        check("abc_digest", 512'(digest), 512'(ABC_DIG));
        check("abc_idle", 512'(busy), 512'(0));

        // 2: 56-byte message spills its length into a second block
        snap();
        q = {};
        for (int i = 0; i < 56; i++) q.push_back(S2[447 - 8*i -: 8]);
        send_msg();
        wait_digest("s2_done");
        check("s2_inits", 512'(init_cnt - base_i), 512'(1));
        check("s2_nexts", 512'(next_cnt - base_n), 512'(1));
        check("s2_block0", blk_log[base_p % 16], S2_BLK0);
        check("s2_block1", blk_log[(base_p + 1) % 16], S2_BLK1);
        check("s2_digest", 512'(digest), 512'(S2_DIG));

        // 3: 64 zero bytes, padding entirely in the second block
        snap();
        q = {};
        for (int i = 0; i < 64; i++) q.push_back(8'h00);
        send_msg();
        wait_digest("z64_done");
        check("z64_inits", 512'(init_cnt - base_i), 512'(1));
        check("z64_nexts", 512'(next_cnt - base_n), 512'(1));
        check("z64_block0", blk_log[base_p % 16], 512'(0));
        check("z64_block1", blk_log[(base_p + 1) % 16], Z_BLK1);
        check("z64_digest", 512'(digest), 512'(sha1_compress(sha1_compress(H0, 512'(0)), Z_BLK1)));

        // 4: core held not-ready while a block waits in ISSUE
        snap();
        hold = 1'b1;
        load_abc();
        send_msg();
        repeat (80) @(negedge clk);
        pulses_seen = 0;
        blk_changed = 0;
        ready_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_init || core_next) pulses_seen++;
            if (core_block !== ABC_BLK) blk_changed++;
            if (msg.ready) ready_seen++;
        end
        check("hold_no_pulse", 512'(pulses_seen), 512'(0));
        check("hold_block_stable", 512'(blk_changed), 512'(0));
        check("hold_in_ready_low", 512'(ready_seen), 512'(0));
        hold = 1'b0;
        #1;
        check("hold_release_init", 512'({core_init, core_next}), 512'(2'b10));
        wait_digest("hold_done");
        check("hold_inits", 512'(init_cnt - base_i), 512'(1));
        check("hold_digest", 512'(digest), 512'(ABC_DIG));

        // 5: reset mid-message, then "abc"
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(8'(8'h30 + i));
        for (int i = 0; i < 10; i++) send_byte(q[i], 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 512'(msg.ready), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_block", core_block, 512'(0));
        check("mid_rst_digest", 512'({digest, digest_valid, busy}), 512'(0));
        snap();
        load_abc();
        send_msg();
        wait_digest("mid_rst_done");
        check("mid_rst_inits", 512'({init_cnt - base_i, next_cnt - base_n}), 512'({32'd1, 32'd0}));
        check("mid_rst_abc_block", blk_log[base_p % 16], ABC_BLK);
        check("mid_rst_abc_digest", 512'(digest), 512'(ABC_DIG));

        // 6: two back-to-back "abc" messages
        snap();
        load_abc();
        send_msg();
        wait_digest("b2b1_done");
        check("b2b1_digest", 512'(digest), 512'(ABC_DIG));
        check("b2b_dvalid_before", 512'(digest_valid), 512'(1));
        send_byte(8'h61, 1'b0);
        check("b2b_dvalid_dropped", 512'(digest_valid), 512'(0));
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_digest("b2b2_done");
        check("b2b2_digest", 512'(digest), 512'(ABC_DIG));
        check("b2b_inits", 512'(init_cnt - base_i), 512'(2));
        check("b2b_nexts", 512'(next_cnt - base_n), 512'(0));

        repeat (5) @(negedge clk);
        check("protocol_violations", 512'(viol_cnt), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
